imm_sequencer: RTL and testbench



---
 rtl/imm_sequencer_pkg.sv | 25 ++
 rtl/imm_sequencer_if.sv | 35 +++
 rtl/imm_wb_fifo.sv | 58 +++++
 rtl/imm_sequencer.sv | 95 +++++++++
 tb/tb_imm_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/imm_sequencer_pkg.sv
// Shared widths, opcodes and the immediate-join helper for the LUI/LLI
// constant builder.
package imm_sequencer_pkg;

    localparam int DATASIZE = 16;
    localparam int IMMHI    = 9;
    localparam int IMMLO    = 7;
    localparam int ADDRSIZE = 3;
    localparam int WINDOW   = 4;
    localparam int AGEW     = $clog2(WINDOW + 1);
    localparam int ENTRYW   = ADDRSIZE + DATASIZE;

    typedef enum logic [1:0] {
        IMMOP_NOP = 2'b00,
        IMMOP_LUI = 2'b01,
        IMMOP_LLI = 2'b10,
        IMMOP_CLR = 2'b11
    } immop_e;

    function automatic logic [DATASIZE-1:0] join_imm(input logic [IMMHI-1:0] hi,
                                                     input logic [IMMLO-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/imm_sequencer_if.sv
// Decode-side command port, register-file snoop and writeback port of the
// immediate sequencer.
interface imm_sequencer_if;
    import imm_sequencer_pkg::*;

    // A transfer happens on a clock edge where valid and ready are both high;
    // the source holds its payload stable while valid is high and ready is low.
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [ADDRSIZE-1:0] cmd_rd;
    logic [IMMHI-1:0]    cmd_imm;

    logic                ext_wr_valid;
    logic [ADDRSIZE-1:0] ext_wr_addr;

    logic                wb_valid;
    logic                wb_ready;
    logic [ADDRSIZE-1:0] wb_addr;
    logic [DATASIZE-1:0] wb_data;

    logic                fuse_hit;
    logic                pend_valid;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_imm, ext_wr_valid, ext_wr_addr, wb_ready,
        input  cmd_ready, wb_valid, wb_addr, wb_data, fuse_hit, pend_valid
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_imm, ext_wr_valid, ext_wr_addr, wb_ready,
        output cmd_ready, wb_valid, wb_addr, wb_data, fuse_hit, pend_valid
    );

endinterface

// File: rtl/imm_wb_fifo.sv
// Two-entry in-order valid/ready FIFO; the head entry is a register so the
// output side has no combinational path from the input side.
module imm_wb_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   cnt_q;
    logic         push;
    logic         pop;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;
    assign count     = cnt_q;
    assign push      = in_valid & (cnt_q != 2'd2);
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= in_data;
                    else               tail_q <= in_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; with one entry the new word becomes the head.
                    if (cnt_q == 2'd1) begin
                        head_q <= in_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imm_sequencer.sv
// Builds full-width constants from LUI/LLI pairs: tracks the pending upper
// half, fuses a matching LLI inside the age window, and queues writebacks.
module imm_sequencer
    import imm_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    imm_sequencer_if.slave bus
);

    logic [1:0]          fifo_count;
    logic                cmd_ready;
    logic                accept;
    immop_e              op;
    logic                is_lui;
    logic                is_lli;
    logic                is_clr;
    logic                snoop;
    logic                fuse;
    logic                push;
    logic [DATASIZE-1:0] push_data;
    logic [IMMLO-1:0]    imm_lo;

    logic                pend_valid_q;
    logic [ADDRSIZE-1:0] pend_rd_q;
    logic [IMMHI-1:0]    pend_hi_q;
    logic [AGEW-1:0]     age_q;
    logic                fuse_hit_q;

    logic                fifo_valid;
    logic [ENTRYW-1:0]   fifo_data;

    // Uses the registered count only, so a same-cycle pop never frees a slot.
    assign cmd_ready = !rst && (fifo_count < 2'd2);
    assign accept    = bus.cmd_valid & cmd_ready;
    assign op        = immop_e'(bus.cmd_op);
    assign imm_lo    = bus.cmd_imm[IMMLO-1:0];

    assign is_lui = accept && (op == IMMOP_LUI);
    assign is_lli = accept && (op == IMMOP_LLI);
    assign is_clr = accept && (op == IMMOP_CLR);

    // An external write to the pending register invalidates it and beats a same-cycle LLI.
    assign snoop = pend_valid_q & bus.ext_wr_valid & (bus.ext_wr_addr == pend_rd_q);
    assign fuse  = is_lli & pend_valid_q & (bus.cmd_rd == pend_rd_q) & !snoop;
    assign push  = is_lui | is_lli;

    always_comb begin
        push_data = join_imm('0, imm_lo);
        if (is_lui)    push_data = join_imm(bus.cmd_imm, '0);
        else if (fuse) push_data = join_imm(pend_hi_q, imm_lo);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_rd_q    <= '0;
            pend_hi_q    <= '0;
            age_q        <= '0;
            fuse_hit_q   <= 1'b0;
        end else begin
            fuse_hit_q <= fuse;
            if (is_lui) begin
                pend_valid_q <= 1'b1;
                pend_rd_q    <= bus.cmd_rd;
                pend_hi_q    <= bus.cmd_imm;
                age_q        <= AGEW'(1);
            end else if (snoop || fuse || is_clr) begin
                pend_valid_q <= 1'b0;
            end else if (pend_valid_q) begin
                if (age_q == AGEW'(WINDOW)) pend_valid_q <= 1'b0;
                else                        age_q        <= age_q + AGEW'(1);
            end
        end
    end

    imm_wb_fifo #(.W(ENTRYW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_data   ({bus.cmd_rd, push_data}),
        .out_valid (fifo_valid),
        .out_ready (bus.wb_ready),
        .out_data  (fifo_data),
        .count     (fifo_count)
    );

    assign bus.cmd_ready  = cmd_ready;
    assign bus.wb_valid   = fifo_valid;
    assign bus.wb_addr    = fifo_data[ENTRYW-1:DATASIZE];
    assign bus.wb_data    = fifo_data[DATASIZE-1:0];
    assign bus.fuse_hit   = fuse_hit_q;
    assign bus.pend_valid = pend_valid_q;

endmodule

// File: tb/tb_imm_sequencer.sv
// Directed bench for imm_sequencer: hand-computed writes go into a scoreboard
// queue and an independent monitor checks them as the DUT presents them.
module tb_imm_sequencer;
    import imm_sequencer_pkg::*;

    logic clk;
    logic rst;
    imm_sequencer_if bus();

    imm_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;
    logic [ENTRYW-1:0] exp_q[$];
    logic cmd_fuse_exp = 1'b0;
    logic exp_fuse = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [1:0] op, input logic [2:0] rd, input logic [8:0] imm,
                        input logic ext_v, input logic [2:0] ext_a,
                        input logic do_push, input logic [2:0] ea, input logic [15:0] ed,
                        input logic f);
        int n;
        bus.cmd_valid    = 1'b1;
        bus.cmd_op       = op;
        bus.cmd_rd       = rd;
        bus.cmd_imm      = imm;
        bus.ext_wr_valid = ext_v;
        bus.ext_wr_addr  = ext_a;
        cmd_fuse_exp     = f;
        @(negedge clk);
        n = 0;
        while (!bus.cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", {31'b0, bus.cmd_ready}, 32'd1);
        if (bus.cmd_ready && do_push) exp_q.push_back({ea, ed});
        @(posedge clk);
        #1;
        bus.cmd_valid    = 1'b0;
        bus.ext_wr_valid = 1'b0;
        cmd_fuse_exp     = 1'b0;
    endtask

    task automatic nop_n(input int n);
        for (int i = 0; i < n; i++) send(2'b00, 3'd0, 9'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(posedge clk) exp_fuse <= (bus.cmd_valid && bus.cmd_ready) ? cmd_fuse_exp : 1'b0;

    always @(negedge clk) begin
        if (!rst && bus.wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {13'b0, bus.wb_addr, bus.wb_data}, 32'hFFFF_FFFF);
            end else if (bus.wb_ready) begin
                logic [ENTRYW-1:0] e;
                e = exp_q.pop_front();
                chk("wb_write", {13'b0, bus.wb_addr, bus.wb_data}, {13'b0, e});
            end else begin
                chk("wb_hold", {13'b0, bus.wb_addr, bus.wb_data}, {13'b0, exp_q[0]});
            end
        end
        if (!rst && (exp_fuse || bus.fuse_hit))
            chk("fuse_hit", {31'b0, bus.fuse_hit}, {31'b0, exp_fuse});
    end

    task automatic chk_reset_values();
        chk("rst_wb_valid",   {31'b0, bus.wb_valid},   32'd0);
        chk("rst_wb_addr",    {29'b0, bus.wb_addr},    32'd0);
        chk("rst_wb_data",    {16'b0, bus.wb_data},    32'd0);
        chk("rst_fuse_hit",   {31'b0, bus.fuse_hit},   32'd0);
        chk("rst_pend_valid", {31'b0, bus.pend_valid}, 32'd0);
        chk("rst_cmd_ready",  {31'b0, bus.cmd_ready},  32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bus.cmd_valid    = 1'b0;
        bus.cmd_op       = 2'b00;
        bus.cmd_rd       = 3'd0;
        bus.cmd_imm      = 9'd0;
        bus.ext_wr_valid = 1'b0;
        bus.ext_wr_addr  = 3'd0;
        bus.wb_ready     = 1'b1;
        rst              = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("cmd_ready_in_reset", {31'b0, bus.cmd_ready}, 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_values();
        @(posedge clk);
        #1;

        // LUI then immediate LLI to the same register fuses.
        send(2'b01, 3'd1, 9'h1A5, 1'b0, 3'd0, 1'b1, 3'd1, 16'hD280, 1'b0);
        chk("pend_after_lui", {31'b0, bus.pend_valid}, 32'd1);
        send(2'b10, 3'd1, 9'h03C, 1'b0, 3'd0, 1'b1, 3'd1, 16'hD2BC, 1'b1);
        chk("pend_after_fuse", {31'b0, bus.pend_valid}, 32'd0);

        // LLI five cycles after LUI is past the window.
        send(2'b01, 3'd2, 9'h001, 1'b0, 3'd0, 1'b1, 3'd2, 16'h0080, 1'b0);
        nop_n(WINDOW);
        send(2'b10, 3'd2, 9'h005, 1'b0, 3'd0, 1'b1, 3'd2, 16'h0005, 1'b0);
        // Four cycles after is the last fusing slot.
        send(2'b01, 3'd2, 9'h001, 1'b0, 3'd0, 1'b1, 3'd2, 16'h0080, 1'b0);
        nop_n(WINDOW - 1);
        send(2'b10, 3'd2, 9'h005, 1'b0, 3'd0, 1'b1, 3'd2, 16'h0085, 1'b1);

        // Snoop in the same cycle as a matching LLI wins.
        send(2'b01, 3'd3, 9'h0FF, 1'b0, 3'd0, 1'b1, 3'd3, 16'h7F80, 1'b0);
        send(2'b10, 3'd3, 9'h001, 1'b1, 3'd3, 1'b1, 3'd3, 16'h0001, 1'b0);
        chk("pend_after_snoop", {31'b0, bus.pend_valid}, 32'd0);

        // CLR drops pending; mismatched rd never fuses.
        send(2'b01, 3'd2, 9'h002, 1'b0, 3'd0, 1'b1, 3'd2, 16'h0100, 1'b0);
        send(2'b11, 3'd0, 9'h000, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0);
        chk("pend_after_clr", {31'b0, bus.pend_valid}, 32'd0);
        send(2'b10, 3'd2, 9'h003, 1'b0, 3'd0, 1'b1, 3'd2, 16'h0003, 1'b0);
        send(2'b01, 3'd6, 9'h004, 1'b0, 3'd0, 1'b1, 3'd6, 16'h0200, 1'b0);
        send(2'b10, 3'd5, 9'h07F, 1'b0, 3'd0, 1'b1, 3'd5, 16'h007F, 1'b0);

        // Snoop alongside a LUI: the new pending entry stands.
        send(2'b01, 3'd5, 9'h004, 1'b0, 3'd0, 1'b1, 3'd5, 16'h0200, 1'b0);
        send(2'b01, 3'd5, 9'h008, 1'b1, 3'd5, 1'b1, 3'd5, 16'h0400, 1'b0);
        send(2'b10, 3'd5, 9'h002, 1'b0, 3'd0, 1'b1, 3'd5, 16'h0402, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: two accepted, third waits until the head drains.
        bus.wb_ready = 1'b0;
        send(2'b01, 3'd4, 9'h100, 1'b0, 3'd0, 1'b1, 3'd4, 16'h8000, 1'b0);
        send(2'b01, 3'd5, 9'h0AA, 1'b0, 3'd0, 1'b1, 3'd5, 16'h5500, 1'b0);
        fork
            send(2'b01, 3'd6, 9'h155, 1'b0, 3'd0, 1'b1, 3'd6, 16'hAA80, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("cmd_ready_full", {31'b0, bus.cmd_ready}, 32'd0);
                    chk("wb_data_held", {16'b0, bus.wb_data}, 32'h8000);
                end
                @(posedge clk);
                #1 bus.wb_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Reset with two queued writes and a pending upper half.
        bus.wb_ready = 1'b0;
        send(2'b01, 3'd7, 9'h003, 1'b0, 3'd0, 1'b1, 3'd7, 16'h0180, 1'b0);
        send(2'b10, 3'd1, 9'h07F, 1'b0, 3'd0, 1'b1, 3'd1, 16'h007F, 1'b0);
        chk("pend_before_reset", {31'b0, bus.pend_valid}, 32'd1);
        chk("count_full_before_reset", {31'b0, bus.cmd_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("cmd_ready_in_reset", {31'b0, bus.cmd_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_reset_values();
        @(posedge clk);
        #1 bus.wb_ready = 1'b1;
        send(2'b10, 3'd7, 9'h011, 1'b0, 3'd0, 1'b1, 3'd7, 16'h0011, 1'b0);
        chk("first_write_latency", {31'b0, bus.wb_valid}, 32'd1);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
